imem_loader: RTL

- Program loader: the write side of the instruction memory.
- Accepts a byte stream over a valid/ready interface and assembles 19-bit instruction words. Each word goes out through the instruction memory write port at consecutive addresses starting from 0.
- Holds the processor core (cpu_hold) while a load is in progress.
- Sits between the host byte link and the instruction memory write port.

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 123 ++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Word layout, stream byte lanes and the loader state encoding live here.
package imem_loader_pkg;

    localparam int unsigned INSTR_WIDTH     = 19;
    localparam int unsigned IMEM_ADDR_WIDTH = 12;
    localparam int unsigned IMEM_SIZE       = 4096;
    localparam int unsigned COUNT_WIDTH     = 16;
    localparam int unsigned BYTES_PER_WORD  = 3;
    localparam int unsigned OPCODE_MSB      = 18;
    localparam int unsigned OPCODE_LSB      = 13;

    // Upper bits of the third word byte must be zero padding.
    localparam logic [7:0] TOP_BYTE_PAD_MASK = 8'hF8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_HDR0  = 4'd1,
        ST_HDR1  = 4'd2,
        ST_B0    = 4'd3,
        ST_B1    = 4'd4,
        ST_B2    = 4'd5,
        ST_WRITE = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERROR = 4'd8
    } state_t;

    function automatic logic [5:0] opcode6(input logic [INSTR_WIDTH-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream (valid/ready) plus the instruction-memory write port.
// The loader uses the slave view; the host side and memory use the master view.
interface imem_loader_if import imem_loader_pkg::*; ();

    logic [7:0]                 rx_data;
    logic                       rx_valid;
    logic                       rx_ready;
    logic                       imem_write_enable;
    logic [IMEM_ADDR_WIDTH-1:0] imem_write_address;
    logic [INSTR_WIDTH-1:0]     imem_write_data;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_write_enable,
        output imem_write_address,
        output imem_write_data
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_write_enable,
        input  imem_write_address,
        input  imem_write_data
    );

endinterface

// File: rtl/imem_loader.sv
// Program loader: parses a count header and 3-byte little-endian words from the
// host stream and writes them to instruction memory from address 0, holding the core.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          load_busy,
    output logic          load_done,
    output logic          load_error
);

    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(IMEM_SIZE);

    state_t                     state, state_nxt;
    logic [COUNT_WIDTH-1:0]     remaining, remaining_nxt;
    logic [IMEM_ADDR_WIDTH-1:0] addr, addr_nxt;
    logic [15:0]                asm_word, asm_nxt;
    logic [IMEM_ADDR_WIDTH-1:0] waddr_nxt;
    logic [INSTR_WIDTH-1:0]     wdata_nxt;
    logic                       we_nxt, rx_ready_nxt, busy_nxt, done_nxt, error_nxt, hold_nxt;
    logic                       xfer;
    logic [COUNT_WIDTH-1:0]     hdr_count;

    assign xfer      = bus.rx_valid & bus.rx_ready;
    assign hdr_count = {bus.rx_data, remaining[7:0]};

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= ST_IDLE;
            remaining              <= '0;
            addr                   <= '0;
            asm_word               <= '0;
            bus.rx_ready           <= 1'b0;
            bus.imem_write_enable  <= 1'b0;
            bus.imem_write_address <= '0;
            bus.imem_write_data    <= '0;
            cpu_hold               <= 1'b0;
            load_busy              <= 1'b0;
            load_done              <= 1'b0;
            load_error             <= 1'b0;
        end else begin
            state                  <= state_nxt;
            remaining              <= remaining_nxt;
            addr                   <= addr_nxt;
            asm_word               <= asm_nxt;
            bus.rx_ready           <= rx_ready_nxt;
            bus.imem_write_enable  <= we_nxt;
            bus.imem_write_address <= waddr_nxt;
            bus.imem_write_data    <= wdata_nxt;
            cpu_hold               <= hold_nxt;
            load_busy              <= busy_nxt;
            load_done              <= done_nxt;
            load_error             <= error_nxt;
        end
    end

    // Next-state decode; byte states advance only on an accepted transfer.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: if (load_start) state_nxt = ST_HDR0;
            ST_HDR0: if (xfer) state_nxt = ST_HDR1;
            ST_HDR1: begin
                if (xfer) begin
                    if (hdr_count == '0 || hdr_count > MAX_COUNT) state_nxt = ST_ERROR;
                    else                                          state_nxt = ST_B0;
                end
            end
            ST_B0: if (xfer) state_nxt = ST_B1;
            ST_B1: if (xfer) state_nxt = ST_B2;
            ST_B2: begin
                if (xfer) begin
                    if ((bus.rx_data & TOP_BYTE_PAD_MASK) != 8'h00) state_nxt = ST_ERROR;
                    else                                            state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: state_nxt = (remaining == COUNT_WIDTH'(1)) ? ST_DONE : ST_B0;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath updates and next values of the registered outputs.
    always_comb begin
        remaining_nxt = remaining;
        addr_nxt      = addr;
        asm_nxt       = asm_word;
        waddr_nxt     = bus.imem_write_address;
        wdata_nxt     = bus.imem_write_data;
        we_nxt        = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: if (state_nxt == ST_HDR0) addr_nxt = '0;
            ST_HDR0: if (xfer) remaining_nxt[7:0]  = bus.rx_data;
            ST_HDR1: if (xfer) remaining_nxt[15:8] = bus.rx_data;
            ST_B0:   if (xfer) asm_nxt[7:0]        = bus.rx_data;
            ST_B1:   if (xfer) asm_nxt[15:8]       = bus.rx_data;
            ST_B2: begin
                if (state_nxt == ST_WRITE) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = addr;
                    wdata_nxt = {bus.rx_data[2:0], asm_word};
                end
            end
            ST_WRITE: begin
                remaining_nxt = remaining - COUNT_WIDTH'(1);
                // The last word may sit at the top address; never step past it.
                if (remaining != COUNT_WIDTH'(1)) addr_nxt = addr + IMEM_ADDR_WIDTH'(1);
            end
            default: ;
        endcase
        rx_ready_nxt = (state_nxt == ST_HDR0) || (state_nxt == ST_HDR1) || (state_nxt == ST_B0) ||
                       (state_nxt == ST_B1)   || (state_nxt == ST_B2);
        busy_nxt     = rx_ready_nxt || (state_nxt == ST_WRITE);
        done_nxt     = (state_nxt == ST_DONE);
        error_nxt    = (state_nxt == ST_ERROR);
        hold_nxt     = busy_nxt || error_nxt;
    end

endmodule
